// File: rtl/ff_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ff_wr_arb_pkg
// Description : Shared types and helpers for the FIFO write-side arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ff_wr_arb_pkg;

    // Raw state encodings, kept for tools and scripts that expect plain codes.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } arb_state_e;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ff_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first set
//               request strictly after 'last', wrapping circularly.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import ff_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ff_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ff_wr_arb
// Description : Round-robin burst arbiter in front of a shared FIFO write
//               port. One requester is granted for up to BURST_MAX words;
//               the data path is a pure combinational mux. The ff_* ports map
//               one-to-one onto the FIFO interface wr_only modport signals
//               (ff_full, ff_wr_en, ff_wr_data).
// Revision    : 1.0 - initial release
// ============================================================================
module ff_wr_arb
    import ff_wr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 8
) (
    input  logic                        clk_ir,
    input  logic                        rst_ih,
    input  logic [NUM_REQ-1:0]          req_vld_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_rdy_o,
    input  logic                        ff_full_i,
    output logic                        ff_wr_en_o,
    output logic [DATA_W-1:0]           ff_wr_data_o,
    output logic                        gnt_vld_o,
    output logic [idx_w(NUM_REQ)-1:0]   gnt_id_o
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [IDX_W-1:0] RST_LAST  = IDX_W'(NUM_REQ - 1);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [IDX_W-1:0]  gnt_id;
    logic [IDX_W-1:0]  last_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [CNT_W-1:0]  beat_cnt;
    logic              granted;
    logic              take_pick;
    logic              gnt_req;
    logic              xfer;
    logic              release_gnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req  (req_vld_i),
        .last (last_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign granted   = (state == S_GRANT);
    assign take_pick = (state == S_IDLE) && pick_any;

    // Granted requester's valid, write data and per-requester ready.
    always_comb begin
        gnt_req      = 1'b0;
        ff_wr_data_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == IDX_W'(i)) begin
                gnt_req = req_vld_i[i];
                if (granted) begin
                    ff_wr_data_o = req_data_i[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // A full FIFO stalls the transfer but never counts as a release.
    assign xfer        = granted & gnt_req & ~ff_full_i;
    assign release_gnt = granted & (~gnt_req | (xfer & (beat_cnt == LAST_BEAT)));

    // Ready is the write enable routed back to the granted requester only.
    always_comb begin
        req_rdy_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy_o[i] = xfer & (gnt_id == IDX_W'(i));
        end
    end

    assign ff_wr_en_o = xfer;
    assign gnt_vld_o  = granted;
    assign gnt_id_o   = gnt_id;

    // Next-state: arbitrate only from IDLE, so every release costs one idle cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_any)    state_nxt = S_GRANT;
            S_GRANT: if (release_gnt) state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant index and round-robin pointer; reset pointer makes requester 0 win first.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            gnt_id   <= '0;
            last_gnt <= RST_LAST;
        end else if (take_pick) begin
            gnt_id   <= pick_idx;
            last_gnt <= pick_idx;
        end
    end

    // Beat counter: cleared on grant entry, advanced on completed transfers only.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            beat_cnt <= '0;
        end else if (take_pick) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
